// File: rtl/ram_delay_ctrl.sv
// Address/enable sequencer that runs an external read-first dual-port RAM as a
// circular delay line: zero-clear sweep, priming fill, then delayed-sample valid.
module ram_delay_ctrl #(
    parameter int PAR_ADDR_WIDTH = 5,
    parameter int PAR_DEF_LEN    = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_ena,
    input  logic                      i_cfg_vld,
    input  logic [PAR_ADDR_WIDTH:0]   i_cfg_len,
    output logic                      o_cfg_rdy,
    output logic                      o_cfg_err,
    output logic                      o_ram_wr_ena,
    output logic [PAR_ADDR_WIDTH-1:0] o_ram_wr_adr,
    output logic                      o_ram_wr_zero,
    output logic                      o_ram_rd_ena,
    output logic [PAR_ADDR_WIDTH-1:0] o_ram_rd_adr,
    output logic                      o_vld,
    output logic                      o_drop,
    output logic [1:0]                o_state
);
    localparam int AW = PAR_ADDR_WIDTH;
    localparam logic [AW:0] MAX_LEN = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t        state_q;
    logic [AW:0]   len_q;
    logic [AW:0]   fill_cnt_q, fill_cnt_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] clr_adr_q;
    logic          vld_q, err_q;
    logic          len_ok, cfg_ok, cfg_bad, strobe;

    always_comb begin
        o_cfg_rdy     = (state_q != ST_CLEAR);
        len_ok        = (i_cfg_len != '0) && (i_cfg_len <= MAX_LEN);
        cfg_ok        = i_cfg_vld && o_cfg_rdy && len_ok;
        cfg_bad       = i_cfg_vld && o_cfg_rdy && !len_ok;
        // A accepted reconfiguration swallows a coincident strobe.
        strobe        = i_ena && o_cfg_rdy && !cfg_ok;
        o_ram_rd_adr  = ptr_q;
        o_ram_rd_ena  = strobe;
        if (state_q == ST_CLEAR) begin
            o_ram_wr_ena  = 1'b1;
            o_ram_wr_adr  = clr_adr_q;
            o_ram_wr_zero = 1'b1;
            o_drop        = i_ena;
        end else begin
            o_ram_wr_ena  = strobe;
            o_ram_wr_adr  = ptr_q;
            o_ram_wr_zero = 1'b0;
            o_drop        = i_ena && cfg_ok;
        end
        ptr_d      = ({1'b0, ptr_q} == (len_q - 1'b1)) ? '0 : ptr_q + 1'b1;
        fill_cnt_d = fill_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_CLEAR;
            len_q      <= (AW+1)'(PAR_DEF_LEN);
            ptr_q      <= '0;
            clr_adr_q  <= '0;
            fill_cnt_q <= '0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            vld_q <= strobe && (state_q == ST_RUN);
            err_q <= cfg_bad;
            case (state_q)
                ST_CLEAR: begin
                    clr_adr_q <= clr_adr_q + 1'b1;
                    if (&clr_adr_q) begin
                        state_q    <= ST_FILL;
                        ptr_q      <= '0;
                        fill_cnt_q <= '0;
                    end
                end
                default: begin
                    if (cfg_ok) begin
                        len_q     <= i_cfg_len;
                        state_q   <= ST_CLEAR;
                        clr_adr_q <= '0;
                    end else if (strobe) begin
                        ptr_q <= ptr_d;
                        if (state_q == ST_FILL) begin
                            fill_cnt_q <= fill_cnt_d;
                            if (fill_cnt_d == len_q) state_q <= ST_RUN;
                        end
                    end
                end
            endcase
        end
    end

    assign o_vld     = vld_q;
    assign o_cfg_err = err_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_ram_delay_ctrl.sv
// Bench for ram_delay_ctrl: a RAM model fed by the DUT, a sample-history model
// checked every cycle, and directed scenarios with literal expectations.
module tb_ram_delay_ctrl;
    localparam int AW  = 5;
    localparam int MAX = 32;
    localparam int DEF = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0, ena = 1'b0, cfg_vld = 1'b0;
    logic [AW:0]   cfg_len = '0;
    logic          cfg_rdy, cfg_err, wr_ena, wr_zero, rd_ena, vld, drop;
    logic [AW-1:0] wr_adr, rd_adr;
    logic [1:0]    state;
    logic [15:0]   din = '0;

    ram_delay_ctrl #(.PAR_ADDR_WIDTH(AW), .PAR_DEF_LEN(DEF)) dut (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_cfg_vld(cfg_vld), .i_cfg_len(cfg_len),
        .o_cfg_rdy(cfg_rdy), .o_cfg_err(cfg_err), .o_ram_wr_ena(wr_ena),
        .o_ram_wr_adr(wr_adr), .o_ram_wr_zero(wr_zero), .o_ram_rd_ena(rd_ena),
        .o_ram_rd_adr(rd_adr), .o_vld(vld), .o_drop(drop), .o_state(state)
    );

    always #5 clk = ~clk;

    // Simple dual-port, read-first RAM with one-cycle read latency.
    logic [15:0] mem [0:MAX-1];
    logic [15:0] rd_q;
    always @(posedge clk) begin
        if (rd_ena === 1'b1) rd_q <= mem[rd_adr];
        if (wr_ena === 1'b1) mem[wr_adr] <= (wr_zero ? 16'd0 : din);
    end

    int n_cmp = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the delay line is described by the accepted-sample history only.
    bit m_known = 0;
    int m_len, m_clr, m_k, e_data;
    bit e_vld, e_err;
    int hist[$];
    int vld_log[$];
    int err_cnt = 0, zcnt = 0;
    bit in_clear, ok, acc;

    always @(negedge clk) begin
        if (m_known) begin
            in_clear = (m_clr < MAX);
            ok = cfg_vld && (cfg_len >= 1) && (cfg_len <= MAX);
            chk("state", state, in_clear ? 0 : ((m_k >= m_len) ? 2 : 1));
            chk("vld", vld, e_vld);
            chk("cfg_err", cfg_err, e_err);
            if (e_vld) chk("rd_data", {16'd0, rd_q}, e_data);
            if (in_clear) begin
                chk("clr_wr_ena", wr_ena, 1);
                chk("clr_wr_adr", wr_adr, m_clr);
                chk("clr_wr_zero", wr_zero, 1);
                chk("clr_rd_ena", rd_ena, 0);
                chk("clr_drop", drop, ena);
                chk("clr_cfg_rdy", cfg_rdy, 0);
            end else begin
                acc = ena && !ok;
                chk("wr_ena", wr_ena, acc);
                chk("rd_ena", rd_ena, acc);
                chk("drop", drop, ena && ok);
                chk("cfg_rdy", cfg_rdy, 1);
                if (acc) begin
                    chk("wr_adr", wr_adr, m_k % m_len);
                    chk("rd_adr", rd_adr, m_k % m_len);
                    chk("wr_zero", wr_zero, 0);
                end
            end
        end
        if (vld === 1'b1) vld_log.push_back(int'(rd_q));
        if (cfg_err === 1'b1) err_cnt++;
        if (wr_ena === 1'b1 && wr_zero === 1'b1) zcnt++;
        // Advance the model to the state after the coming edge.
        if (rst) begin
            m_known = 1; m_len = DEF; m_clr = 0; m_k = 0;
            hist.delete(); e_vld = 0; e_err = 0;
        end else if (m_known) begin
            e_vld = 0; e_err = 0;
            if (in_clear) begin
                m_clr++;
            end else begin
                e_err = cfg_vld && !ok;
                if (ok) begin
                    m_len = int'(cfg_len); m_clr = 0; m_k = 0; hist.delete();
                end else if (ena) begin
                    e_vld = (m_k >= m_len);
                    if (e_vld) e_data = hist[m_k - m_len];
                    hist.push_back(int'(din));
                    m_k++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear();
        for (int i = 0; i < MAX; i++) tick();
    endtask

    initial begin
        // Reset, then an idle clear sweep of addresses 0..31.
        rst = 1; tick(); tick();
        rst = 0; zcnt = 0;
        chk("rst_state", state, 0);
        chk("rst_vld", vld, 0);
        for (int i = 0; i < MAX - 1; i++) tick();
        chk("clear_not_done", state, 0);
        tick();
        chk("clear_done_state", state, 1);
        chk("clear_done_rdy", cfg_rdy, 1);
        chk("zero_writes", zcnt, 32);

        // Default length, continuous ramp.
        vld_log.delete();
        for (int i = 0; i < 110; i++) begin din = 16'(i); ena = 1; tick(); end
        ena = 0; tick();
        chk("ramp_vld_count", vld_log.size(), 78);
        chk("ramp_first", vld_log[0], 0);
        chk("ramp_strobe100", vld_log[68], 68);

        // Reconfigure to 5 with a coincident strobe.
        cfg_vld = 1; cfg_len = 6'd5; ena = 1; din = 16'd999; #1;
        chk("cfg_drop", drop, 1);
        tick();
        cfg_vld = 0; ena = 0; vld_log.delete();
        for (int i = 0; i < MAX; i++) begin
            ena = (i % 4 == 1);
            cfg_vld = (i == 3); cfg_len = '0;
            tick();
        end
        cfg_vld = 0; ena = 0;
        chk("len5_fill", state, 1);
        for (int i = 0; i < 8; i++) begin din = 16'(1000 + i); ena = 1; tick(); end
        ena = 0; tick();
        chk("len5_vld_count", vld_log.size(), 3);
        chk("len5_first", vld_log[0], 1000);
        chk("len5_third", vld_log[2], 1002);

        // Rejected lengths 0 and 33 while streaming.
        err_cnt = 0; vld_log.delete();
        for (int i = 0; i < 20; i++) begin
            din = 16'(2000 + i); ena = 1;
            cfg_vld = (i == 4) || (i == 10);
            cfg_len = (i == 10) ? 6'd33 : 6'd0;
            tick();
        end
        cfg_vld = 0; ena = 0; tick(); tick();
        chk("err_pulses", err_cnt, 2);
        chk("err_vld_count", vld_log.size(), 20);
        chk("err_first", vld_log[0], 1003);
        chk("err_last", vld_log[19], 2014);

        // len=1 with sparse strobes.
        cfg_vld = 1; cfg_len = 6'd1; tick(); cfg_vld = 0;
        wait_clear(); vld_log.delete();
        for (int i = 0; i < 12; i++) begin
            din = 16'(3000 + i); ena = 1; tick(); ena = 0; tick(); tick();
        end
        tick();
        chk("len1_vld_count", vld_log.size(), 11);
        chk("len1_last", vld_log[10], 3010);

        // len=MAX.
        cfg_vld = 1; cfg_len = 6'd32; tick(); cfg_vld = 0;
        wait_clear(); vld_log.delete();
        for (int i = 0; i < 70; i++) begin din = 16'(4000 + i); ena = 1; tick(); end
        ena = 0; tick();
        chk("lenmax_vld_count", vld_log.size(), 38);
        chk("lenmax_last", vld_log[37], 4037);

        // Reset from a short length mid-RUN, then again mid-CLEAR.
        cfg_vld = 1; cfg_len = 6'd4; tick(); cfg_vld = 0;
        wait_clear();
        for (int i = 0; i < 10; i++) begin din = 16'(5000 + i); ena = 1; tick(); end
        rst = 1; tick(); rst = 0; ena = 0;
        chk("rst_run_state", state, 0);
        chk("rst_run_vld", vld, 0);
        chk("rst_run_adr", wr_adr, 0);
        chk("rst_run_wr", wr_ena, 1);
        for (int i = 0; i < 17; i++) tick();
        chk("mid_clear_adr", wr_adr, 17);
        rst = 1; tick(); rst = 0;
        chk("rst_clr_adr", wr_adr, 0);
        chk("rst_clr_state", state, 0);
        wait_clear(); vld_log.delete();
        for (int i = 0; i < 40; i++) begin din = 16'(6000 + i); ena = 1; tick(); end
        ena = 0; tick();
        chk("rst_len_vld_count", vld_log.size(), 8);
        chk("rst_len_first", vld_log[0], 6000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_delay_ctrl.md
# ram_delay_ctrl

Address and enable sequencer for the RAM-based sample delay line. It drives an external simple dual-port, read-first RAM with a one-cycle read latency as a circular buffer whose delay length is programmable at run time. Each (re)configuration runs a zero-clear sweep and then a priming phase, and o_vld marks only genuinely delayed samples. The block sits between the sample-strobe source and the delay RAM in the frame-detector datapath; the RAM data path itself stays outside.

## Interface
- PAR_ADDR_WIDTH, 5: RAM address width; RAM depth MAX = 2**PAR_ADDR_WIDTH.
- PAR_DEF_LEN, 32: delay length loaded at reset; legal range 1..MAX.

- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_ena  in  1  sample strobe, one sample per asserted cycle.
- i_cfg_vld  in  1  new-length request.
- i_cfg_len  in  PAR_ADDR_WIDTH+1  requested delay length in samples.
- o_cfg_rdy  out  1  request can be accepted this cycle.
- o_cfg_err  out  1  one-cycle pulse: a request was rejected.
- o_ram_wr_ena  out  1  RAM write enable.
- o_ram_wr_adr  out  PAR_ADDR_WIDTH  RAM write address.
- o_ram_wr_zero  out  1  write data mux selects zero (clear sweep).
- o_ram_rd_ena  out  1  RAM read enable.
- o_ram_rd_adr  out  PAR_ADDR_WIDTH  RAM read address.
- o_vld  out  1  RAM read data is a valid delayed sample (cycle after the strobe).
- o_drop  out  1  strobe in this cycle was discarded.
- o_state  out  2  0=CLEAR, 1=FILL, 2=RUN.

## Operation
- Registers:
  - len, width AW+1.
  - ptr, width AW.
  - clr_adr, width AW.
  - fill_cnt, width AW+1.
  - state.
- Reset: len=PAR_DEF_LEN, state=CLEAR, clr_adr=0, ptr=0, fill_cnt=0, o_vld=0, o_cfg_err=0.
- CLEAR:
  - Every cycle: o_ram_wr_ena=1, o_ram_wr_adr=clr_adr, o_ram_wr_zero=1; clr_adr increments.
  - Strobes are ignored: o_drop=i_ena, no read.
  - After clr_adr=MAX-1 is written: state=FILL, ptr=0, fill_cnt=0.
  - o_cfg_rdy=0.
- FILL and RUN, on each i_ena cycle:
  - o_ram_wr_ena=1, o_ram_rd_ena=1, o_ram_wr_adr=o_ram_rd_adr=ptr, o_ram_wr_zero=0.
  - ptr advances, wrapping to 0 after ptr==len-1.
  - Because the RAM is read-first, the read returns the sample written len strobes earlier.
- FILL: fill_cnt increments per strobe. The strobe that brings fill_cnt to len moves the block to RUN on the next cycle. The first len strobes never raise o_vld.
- RUN: o_vld is i_ena registered by one cycle.
- No strobe: all RAM enables are 0 and ptr holds.
- Configuration (o_cfg_rdy=1 in FILL and RUN):
  - Valid request, 1≤i_cfg_len≤MAX: len loads, state=CLEAR, clr_adr=0. A strobe in the same cycle is dropped (o_drop=1, no RAM access, no o_vld).
  - Invalid request (0 or >MAX): o_cfg_err pulses the next cycle; len and state are unchanged; a coincident strobe is processed normally.
  - i_cfg_vld while in CLEAR is ignored, with no error.
- Widths: the ptr wrap compare uses len-1 zero-extended to AW+1 bits. len=MAX wraps naturally at 2**AW-1. For len=1, ptr stays at 0.

## Timing
- o_ram_*, o_drop and o_cfg_rdy are combinational from i_ena, i_cfg_vld and registered state. This gives zero-latency addressing.
- o_vld, o_cfg_err and o_state are registered.
- Sample latency:
  - o_vld for strobe k (0-based) appears at cycle t_k+1, for k ≥ len counted from the first FILL strobe.
  - The RAM data at that cycle equals the sample of strobe k-len.
- CLEAR lasts exactly MAX cycles, whether entered from reset or from reconfiguration.
- Back-to-back strobes are supported at one per cycle with no bubbles.
- i_rst has priority over everything, including mid-CLEAR and mid-cfg. Next-cycle outputs: o_vld=0, o_state=0, o_ram_wr_ena=1 (clear address 0).

## Test plan
- Reset, then idle for 32 cycles: exactly addresses 0..31 written with o_ram_wr_zero=1; o_state=1 at cycle 33; o_cfg_rdy rises with it.
- Default len 32, continuous strobes carrying ramp data 0,1,2…: strobes 0–31 give no o_vld; strobe 32 gives o_vld with data 0; strobe 100 gives data 68; ptr wraps 31→0 with no gap.
- In RUN, i_cfg_len=5 with a coincident strobe: o_drop=1; CLEAR for 32 cycles; then the 6th strobe yields o_vld with data equal to the 1st strobe after CLEAR.
- i_cfg_len=0, then i_cfg_len=33: o_cfg_err pulses once each; o_vld stream and ptr are unaffected.
- len=1 with strobes every 3rd cycle: rd_adr=wr_adr=0 always; each o_vld carries the previous sample. len=32 (MAX) also wraps correctly.
- i_rst asserted mid-RUN and mid-CLEAR (clr_adr=17): next cycle o_state=0, clear restarts at address 0, o_vld=0, len returns to 32.
